// File: rtl/mc_controller_fsm.sv
// ---------------------------------------------------------------------------
// mc_controller_fsm
//
// Main control FSM of a multicycle MIPS core. The opcode is decoded over
// several cycles and drives the datapath enables, mux selects and the 3-bit
// aluop consumed by the downstream ALU decoder. A memory-ready handshake
// stretches the fetch, load-read and store-write cycles. A sticky watchdog
// flags memory that stalls for MAX_WAIT consecutive cycles.
//
// Build option:
//   MC_CONTROLLER_BNE_EN - when defined, opcode 000101 (bne) dispatches to
//                          the branch state and drives branch_ne_o.
//                          Otherwise bne is illegal and branch_ne_o is 0.
//
// Parameters:
//   MAX_WAIT      - consecutive memory wait cycles before mem_timeout_o sets
//                   (1..255)
//
// Ports:
//   clk           - rising-edge clock
//   reset         - asynchronous, active-low reset
//   op_i          - opcode from the instruction register (sampled in DECODE)
//   mem_ready_i   - memory completes the current access this cycle
//   pcwrite_o, branch_o, irwrite_o, regwrite_o, memwrite_o - write enables
//   iord_o, alusrca_o, memtoreg_o, regdst_o                - mux selects
//   alusrcb_o     - ALU B select (00 reg, 01 const 4, 10 imm, 11 imm<<2)
//   pcsrc_o       - PC source (00 ALU result, 01 ALUOut, 10 jump target)
//   aluop_o       - 000 add, 001 sub, 010 and, 011 or, 100 slt, 111 funct
//   branch_ne_o   - branch on not-equal (bne builds only)
//   mem_timeout_o - sticky watchdog flag
// ---------------------------------------------------------------------------
module mc_controller_fsm #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op_i,
    input  logic       mem_ready_i,
    output logic       pcwrite_o,
    output logic       branch_o,
    output logic       irwrite_o,
    output logic       regwrite_o,
    output logic       memwrite_o,
    output logic       iord_o,
    output logic       alusrca_o,
    output logic       memtoreg_o,
    output logic       regdst_o,
    output logic [1:0] alusrcb_o,
    output logic [1:0] pcsrc_o,
    output logic [2:0] aluop_o,
    output logic       branch_ne_o,
    output logic       mem_timeout_o
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;
    logic       waiting;

    // Raw enables before reset gating.
    logic pcwrite_en, branch_en, irwrite_en, regwrite_en, memwrite_en;

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the async reset sits in the sensitivity list.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            op_q       <= '0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // ---------------- next-state logic ----------------
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_FETCH:  if (mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                op_d = op_i;
                case (op_i)
                    OP_LW, OP_SW:                      state_d = S_MEMADR;
                    OP_RTYPE:                          state_d = S_EXEC;
                    OP_BEQ:                            state_d = S_BRANCH;
`ifdef MC_CONTROLLER_BNE_EN
                    OP_BNE:                            state_d = S_BRANCH;
`endif
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IMMEX;
                    OP_J:                              state_d = S_JUMP;
                    default:                           state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready_i) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready_i) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_IMMEX:  state_d = S_IMMWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // ---------------- watchdog ----------------
    // Only the three memory states can stall, and they stall exactly when
    // mem_ready_i is low; every other cycle either completes the access or
    // changes state, so the counter clears whenever we are not waiting.
    always_comb begin
        waiting    = ((state_q == S_FETCH) || (state_q == S_MEMRD) ||
                      (state_q == S_MEMWR)) && !mem_ready_i;
        wait_cnt_d = '0;
        if (waiting) begin
            wait_cnt_d = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
        end
        timeout_d  = timeout_q | (wait_cnt_q == MAX_WAIT_C);
    end

    // ---------------- output logic ----------------
    always_comb begin
        pcwrite_en  = 1'b0;
        branch_en   = 1'b0;
        irwrite_en  = 1'b0;
        regwrite_en = 1'b0;
        memwrite_en = 1'b0;
        iord_o      = 1'b0;
        alusrca_o   = 1'b0;
        memtoreg_o  = 1'b0;
        regdst_o    = 1'b0;
        alusrcb_o   = 2'b00;
        pcsrc_o     = 2'b00;
        aluop_o     = 3'b000;
        case (state_q)
            S_FETCH: begin
                alusrcb_o  = 2'b01;
                irwrite_en = mem_ready_i;
                pcwrite_en = mem_ready_i;
            end
            S_DECODE: alusrcb_o = 2'b11;
            S_MEMADR: begin
                alusrca_o = 1'b1;
                alusrcb_o = 2'b10;
            end
            S_MEMRD:  iord_o = 1'b1;
            S_MEMWB: begin
                regwrite_en = 1'b1;
                memtoreg_o  = 1'b1;
            end
            S_MEMWR: begin
                iord_o      = 1'b1;
                memwrite_en = mem_ready_i;
            end
            S_EXEC: begin
                alusrca_o = 1'b1;
                aluop_o   = 3'b111;
            end
            S_ALUWB: begin
                regdst_o    = 1'b1;
                regwrite_en = 1'b1;
            end
            S_BRANCH: begin
                alusrca_o = 1'b1;
                aluop_o   = 3'b001;
                branch_en = 1'b1;
                pcsrc_o   = 2'b01;
            end
            S_IMMEX: begin
                alusrca_o = 1'b1;
                alusrcb_o = 2'b10;
                case (op_q)
                    OP_ANDI: aluop_o = 3'b010;
                    OP_ORI:  aluop_o = 3'b011;
                    OP_SLTI: aluop_o = 3'b100;
                    default: aluop_o = 3'b000;
                endcase
            end
            S_IMMWB:  regwrite_en = 1'b1;
            S_JUMP: begin
                pcwrite_en = 1'b1;
                pcsrc_o    = 2'b10;
            end
            default: ;
        endcase
    end

    // FETCH gates its enables with mem_ready_i, so while reset holds the
    // state in FETCH the enables must also be masked by reset itself.
    assign pcwrite_o     = pcwrite_en  & reset;
    assign branch_o      = branch_en   & reset;
    assign irwrite_o     = irwrite_en  & reset;
    assign regwrite_o    = regwrite_en & reset;
    assign memwrite_o    = memwrite_en & reset;
    assign mem_timeout_o = timeout_q;

`ifdef MC_CONTROLLER_BNE_EN
    assign branch_ne_o = (state_q == S_BRANCH) && (op_q == OP_BNE);
`else
    assign branch_ne_o = 1'b0;
`endif

endmodule
